// File: rtl/sc_fir_pkg.sv
// Shared constants and types for the stochastic FIR tap accumulator.
// Default widths, LFSR polynomial/seeds, FSM state and tap/coef word.
package sc_fir_pkg;

  localparam int N_DEF    = 12;
  localparam int TAPS_DEF = 19;
  localparam int POW2N    = 1 << N_DEF;

  // x^12 + x^6 + x^4 + x + 1; the MSB term must stay set for
  // the zero-insertion trick in sc_lfsr_db to work
  localparam logic [N_DEF-1:0] LFSR_POLY = 12'h829;
  localparam logic [N_DEF-1:0] DATA_SEED = 12'h001;
  localparam logic [N_DEF-1:0] COEF_SEED = 12'hA5C;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef logic [N_DEF:0] word_t;

endpackage

// File: rtl/sc_lfsr_db.sv
// N-bit de Bruijn LFSR: Fibonacci LFSR with the all-zero state
// spliced in, giving period 2^N. Synchronous seed load and enable.
module sc_lfsr_db
  import sc_fir_pkg::*;
#(
  parameter int           N    = N_DEF,
  parameter logic [N-1:0] POLY = LFSR_POLY,
  parameter logic [N-1:0] SEED = DATA_SEED
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  output logic [N-1:0] q
);

  logic [N-1:0] lfsr_q, lfsr_d;
  logic         fb;

  always_comb begin
    // flipping feedback when the low bits are zero routes
    // 100..0 -> 000..0 -> 000..1
    fb = (^(lfsr_q & POLY)) ^ (lfsr_q[N-2:0] == '0);
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = SEED;
    end else if (en) begin
      lfsr_d = {lfsr_q[N-2:0], fb};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/sc_fir_tap_accum.sv
// Stochastic-computing FIR tap accumulator over a 2^N-cycle frame.
// Define SC_BIPOLAR_EN for XNOR (bipolar) products instead of AND.
module sc_fir_tap_accum
  import sc_fir_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int TAPS = TAPS_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [N:0] tap  [TAPS],
  input  logic [N:0] coef [TAPS],
  input  logic       start,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [N:0] result
);

  localparam int SW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [N-1:0]  CYC_LAST = '1;
  localparam logic [SW-1:0] SEL_LAST = SW'(TAPS - 1);

  state_e state_q, state_d;

  logic [N-1:0]  snap_tap_q  [TAPS];
  logic [N-1:0]  snap_tap_d  [TAPS];
  logic [N:0]    snap_coef_q [TAPS];
  logic [N:0]    snap_coef_d [TAPS];
  logic [N-1:0]  cyc_q, cyc_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [N:0]    ones_q, ones_d;
  logic          valid_q, valid_d;

  logic [N-1:0] data_rn, coef_rn;
  logic launch, run_en, ack;
  logic d_bit, c_bit, p_bit;
  logic unused_tap_msb;

  sc_lfsr_db #(
    .N    (N),
    .POLY (LFSR_POLY),
    .SEED (DATA_SEED)
  ) u_data_lfsr (
    .clock (clock),
    .reset (reset),
    .load  (launch),
    .en    (run_en),
    .q     (data_rn)
  );

  sc_lfsr_db #(
    .N    (N),
    .POLY (LFSR_POLY),
    .SEED (COEF_SEED)
  ) u_coef_lfsr (
    .clock (clock),
    .reset (reset),
    .load  (launch),
    .en    (run_en),
    .q     (coef_rn)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (cyc_q == CYC_LAST) state_d = DONE;
      DONE: if (ack) state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run_en    = (state_q == RUN);
    ack       = (state_q == DONE) && valid_q && out_ready;
    launch    = start && ((state_q == IDLE) || ack);
    busy      = run_en;
    out_valid = valid_q;
    result    = ones_q;
  end

  // only the selected tap's product bit reaches the counter
  always_comb begin
    d_bit = data_rn < snap_tap_q[sel_q];
    c_bit = {1'b0, coef_rn} < snap_coef_q[sel_q];
`ifdef SC_BIPOLAR_EN
    p_bit = ~(d_bit ^ c_bit);
`else
    p_bit = d_bit & c_bit;
`endif
  end

  always_comb begin
    unused_tap_msb = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      unused_tap_msb = unused_tap_msb ^ tap[i][N];
    end
  end

  always_comb begin
    snap_tap_d  = snap_tap_q;
    snap_coef_d = snap_coef_q;
    cyc_d       = cyc_q;
    sel_d       = sel_q;
    ones_d      = ones_q;
    valid_d     = valid_q;
    if (launch) begin
      for (int i = 0; i < TAPS; i++) begin
        snap_tap_d[i]  = tap[i][N-1:0];
        snap_coef_d[i] = coef[i];
      end
      cyc_d   = '0;
      sel_d   = '0;
      ones_d  = '0;
      valid_d = 1'b0;
    end else if (run_en) begin
      cyc_d  = cyc_q + N'(1);
      sel_d  = (sel_q == SEL_LAST) ? '0 : sel_q + SW'(1);
      ones_d = ones_q + (N+1)'(p_bit);
    end else if (state_q == DONE) begin
      // first DONE cycle raises valid; handshake drops it
      if (!valid_q) begin
        valid_d = 1'b1;
      end else if (out_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_q   <= '0;
      sel_q   <= '0;
      ones_q  <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        snap_tap_q[i]  <= '0;
        snap_coef_q[i] <= '0;
      end
    end else begin
      cyc_q       <= cyc_d;
      sel_q       <= sel_d;
      ones_q      <= ones_d;
      valid_q     <= valid_d;
      snap_tap_q  <= snap_tap_d;
      snap_coef_q <= snap_coef_d;
    end
  end

endmodule

// File: tb/tb_sc_fir_tap_accum.sv
// Self-checking bench for sc_fir_tap_accum against a frame-level
// reference model of the LFSR streams and round-robin select.
module tb_sc_fir_tap_accum;
  import sc_fir_pkg::*;

  localparam int NT    = 19;
  localparam int FRAME = 4096;
  localparam int POLY  = 'h829;
  localparam int DSEED = 'h001;
  localparam int CSEED = 'hA5C;

  logic  clock;
  logic  reset;
  logic  start;
  logic  out_ready;
  logic  busy;
  logic  out_valid;
  logic [12:0] result;
  word_t tap_s  [NT];
  word_t coef_s [NT];

  int n_vec;
  int n_err;
  int data_seq [FRAME];
  int coef_seq [FRAME];

  sc_fir_tap_accum dut (
    .clock     (clock),
    .reset     (reset),
    .tap       (tap_s),
    .coef      (coef_s),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int lfsr_next(input int x);
    int fb;
    fb = 0;
    for (int b = 0; b < 12; b++) begin
      if (((x >> b) & 1) == 1 && ((POLY >> b) & 1) == 1)
        fb = fb ^ 1;
    end
    if ((x & 'h7FF) == 0) fb = fb ^ 1;
    return ((x << 1) & 'hFFF) | fb;
  endfunction

  task automatic build_seqs();
    data_seq[0] = DSEED;
    coef_seq[0] = CSEED;
    for (int k = 1; k < FRAME; k++) begin
      data_seq[k] = lfsr_next(data_seq[k-1]);
      coef_seq[k] = lfsr_next(coef_seq[k-1]);
    end
  endtask

  // expected ones-count for the stimulus currently on tap_s/coef_s
  function automatic int model();
    int ones;
    int t;
    bit d;
    bit c;
    ones = 0;
    for (int k = 0; k < FRAME; k++) begin
      t = k % NT;
      d = data_seq[k] < int'(tap_s[t][11:0]);
      c = coef_seq[k] < int'(coef_s[t]);
`ifdef SC_BIPOLAR_EN
      if (d == c) ones++;
`else
      if (d && c) ones++;
`endif
    end
    return ones;
  endfunction

  task automatic fill(input int tv, input int cv);
    for (int i = 0; i < NT; i++) begin
      tap_s[i]  = 13'(tv);
      coef_s[i] = 13'(cv);
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < NT; i++) begin
      tap_s[i]  = 13'($urandom_range(0, 8191));
      coef_s[i] = 13'($urandom_range(0, 4096));
    end
  endtask

  task automatic start_frame(input bit scr);
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    if (scr) scramble();
  endtask

  // cycles counted from just after the start edge
  task automatic wait_done(input int poke_at,
                           output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (out_valid !== 1'b1 && cyc < 5000) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clock); #1;
      cyc++;
      start = (cyc == poke_at);
    end
    start = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_vec++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || result !== 13'd0) begin
      n_err++;
      $display("FAIL reset_state busy=%b valid=%b result=%0d want 0/0/0",
               busy, out_valid, result);
    end
    start = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle busy=%b want 0", busy);
    end
  endtask

  task automatic test_full_scale();
    int cyc;
    int bcnt;
    fill(4095, 4096);
    start_frame(1'b1);
    wait_done(-1, cyc, bcnt);
    n_vec++;
    if (result !== 13'd4095) begin
      n_err++;
      $display("FAIL full_result got %0d want 4095", result);
    end
    n_vec++;
    if (cyc != FRAME + 1) begin
      n_err++;
      $display("FAIL full_latency got %0d want %0d", cyc, FRAME + 1);
    end
    n_vec++;
    if (bcnt != FRAME) begin
      n_err++;
      $display("FAIL full_busy got %0d want %0d", bcnt, FRAME);
    end
    drain();
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL full_drain valid=%b busy=%b want 0/0",
               out_valid, busy);
    end
  endtask

  task automatic test_zero_operands();
    int cyc;
    int bcnt;
    int exp;
    for (int pass = 0; pass < 2; pass++) begin
      scramble();
      for (int i = 0; i < NT; i++) begin
        if (pass == 0) tap_s[i] = 13'd0;
        else coef_s[i] = 13'd0;
      end
      exp = model();
      start_frame(1'b1);
      wait_done(-1, cyc, bcnt);
      n_vec++;
      if (result !== 13'(exp)) begin
        n_err++;
        $display("FAIL zero_op%0d got %0d want %0d", pass, result, exp);
      end
`ifndef SC_BIPOLAR_EN
      n_vec++;
      if (result !== 13'd0) begin
        n_err++;
        $display("FAIL zero_and%0d got %0d want 0", pass, result);
      end
`endif
      drain();
    end
  endtask

  task automatic test_zero_both();
    int cyc;
    int bcnt;
    int exp;
`ifdef SC_BIPOLAR_EN
    exp = 4096;
`else
    exp = 0;
`endif
    fill(0, 0);
    start_frame(1'b0);
    wait_done(-1, cyc, bcnt);
    n_vec++;
    if (result !== 13'(exp)) begin
      n_err++;
      $display("FAIL zero_both got %0d want %0d", result, exp);
    end
    drain();
  endtask

  task automatic test_single_tap();
    int cyc;
    int bcnt;
    int exp;
    fill(0, 4096);
    tap_s[0] = 13'd2048;
    exp = model();
    start_frame(1'b1);
    wait_done(-1, cyc, bcnt);
    n_vec++;
    if (result !== 13'(exp)) begin
      n_err++;
      $display("FAIL single_tap got %0d want %0d", result, exp);
    end
    drain();
  endtask

  task automatic test_random();
    int cyc;
    int bcnt;
    int exp;
    for (int f = 0; f < 3; f++) begin
      scramble();
      for (int i = 0; i < NT; i++) begin
        if (f == 1) coef_s[i] = $urandom_range(0, 1) ? 13'd4096 : 13'd0;
        if (f == 2) tap_s[i] = 13'($urandom_range(0, 255));
      end
      exp = model();
      start_frame(1'b1);
      wait_done(-1, cyc, bcnt);
      n_vec++;
      if (result !== 13'(exp) || cyc != FRAME + 1) begin
        n_err++;
        $display("FAIL random%0d got %0d@%0d want %0d@%0d",
                 f, result, cyc, exp, FRAME + 1);
      end
      drain();
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int bcnt;
    int exp_a;
    int exp_b;
    int bad;
    scramble();
    exp_a = model();
    start_frame(1'b1);
    wait_done(2000, cyc, bcnt);
    n_vec++;
    if (result !== 13'(exp_a) || cyc != FRAME + 1 || bcnt != FRAME) begin
      n_err++;
      $display("FAIL b2b_first got %0d cyc %0d busy %0d want %0d/%0d/%0d",
               result, cyc, bcnt, exp_a, FRAME + 1, FRAME);
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      start = (i >= 10 && i < 20);
      @(posedge clock); #1;
      if (out_valid !== 1'b1 || busy !== 1'b0 || result !== 13'(exp_a))
        bad++;
    end
    start = 1'b0;
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL b2b_hold unstable %0d cycles want 0", bad);
    end
    scramble();
    exp_b = model();
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    out_ready = 1'b0;
    scramble();
    n_vec++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_restart busy=%b valid=%b want 1/0",
               busy, out_valid);
    end
    wait_done(-1, cyc, bcnt);
    n_vec++;
    if (result !== 13'(exp_b) || cyc != FRAME + 1) begin
      n_err++;
      $display("FAIL b2b_second got %0d@%0d want %0d@%0d",
               result, cyc, exp_b, FRAME + 1);
    end
    drain();
  endtask

  task automatic test_reset_abort();
    int cyc;
    int bcnt;
    int exp;
    int seen;
    scramble();
    exp = model();
    start_frame(1'b0);
    repeat (1000) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    start = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || result !== 13'd0) begin
      n_err++;
      $display("FAIL abort_state busy=%b valid=%b result=%0d want 0/0/0",
               busy, out_valid, result);
    end
    seen = 0;
    repeat (50) begin
      @(posedge clock); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL abort_quiet active %0d cycles want 0", seen);
    end
    start_frame(1'b0);
    wait_done(-1, cyc, bcnt);
    n_vec++;
    if (result !== 13'(exp) || cyc != FRAME + 1) begin
      n_err++;
      $display("FAIL abort_rerun got %0d@%0d want %0d@%0d",
               result, cyc, exp, FRAME + 1);
    end
    drain();
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    fill(0, 0);
    build_seqs();
    test_reset();
    test_full_scale();
    test_zero_operands();
    test_zero_both();
    test_single_tap();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sc_fir_tap_accum.md
SC_FIR_TAP_ACCUM -- requirements
Module: sc_fir_tap_accum

Interface
REQ-001 Parameter N, default 12, sample magnitude width; frame length is 2^N cycles.
REQ-002 Parameter TAPS, default 19, number of delay-line taps consumed.
REQ-003 clock  input  1  sole clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tap  input  TAPS x (N+1)  binary tap samples from the upstream delay line; only bits [N-1:0] are used and bit N is ignored.
REQ-006 coef  input  TAPS x (N+1)  unsigned coefficient probabilities in the range 0..2^N; the value 2^N means probability 1.
REQ-007 start  input  1  request to begin a frame; it is sampled only when the block can accept it.
REQ-008 busy  output  1  high in RUN.
REQ-009 out_valid  output  1  result is valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  N+1  ones-count of the frame output bitstream, range 0..2^N.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE; the reset state is IDLE.
REQ-013 In IDLE with start=1, the block SHALL snapshot tap[] and coef[] into internal registers, clear the ones-counter, the cycle counter and the select counter, load both LFSR seeds, and enter RUN.
REQ-014 RUN SHALL last exactly 2^N cycles, each producing one output bit; after the last RUN cycle the block enters DONE, and out_valid is high from the following cycle.
REQ-015 Data stream: each cycle, bit d_i = (data_lfsr < snap_tap[i][N-1:0]); one shared N-bit data LFSR serves all taps.
REQ-016 Coefficient stream: each cycle, bit c_i = ({1'b0,coef_lfsr} < snap_coef[i]); one shared coefficient LFSR with a different seed serves all taps.
REQ-017 Product bit: p_i = d_i AND c_i (see REQ-027 for the alternative).
REQ-018 Scaled add: a round-robin select counter runs 0..TAPS-1, wraps to 0 and advances every RUN cycle; the output bit is p_sel.
REQ-019 The ones-counter (N+1 bits) SHALL increment when the output bit is 1; it cannot overflow because its maximum is 2^N.
REQ-020 Both LFSRs SHALL be de Bruijn (zero-inserted) N-bit sequences with period exactly 2^N, so each value 0..2^N-1 occurs once per frame.
REQ-021 In DONE, result and out_valid SHALL hold stable until out_ready=1.
REQ-022 If out_ready=1 and start=0 in DONE, the block goes to IDLE; if out_ready=1 and start=1 in the same cycle, it performs the REQ-013 actions and enters RUN directly (back-to-back frames).
REQ-023 A start during RUN, or during DONE with out_ready=0, SHALL be ignored with no queuing.
REQ-024 Changes on tap[]/coef[] after the snapshot SHALL NOT affect the frame in progress.

Reset
REQ-025 Reset SHALL force IDLE with busy=0, out_valid=0, result=0, all counters at 0 and the LFSRs at their seeds.
REQ-026 Reset asserted mid-RUN or mid-DONE SHALL abort the frame with no partial result emitted; reset has priority over start.

Configuration
REQ-027 Macro SC_BIPOLAR_EN.
- Defined: p_i = d_i XNOR c_i, and result is interpreted as bipolar (2*result/2^N - 1).
- Undefined: AND product, unipolar interpretation.
- All other behaviour and timing are identical in both builds.

Structure
REQ-028 Package sc_fir_pkg SHALL hold:
- the N and TAPS defaults and POW2N;
- the LFSR feedback polynomial and both seeds;
- the FSM state enum typedef;
- the tap/coef word typedef.
REQ-029 A sub-module sc_lfsr_db (an N-bit de Bruijn LFSR with seed-load and enable) SHALL be instantiated twice.

Verification
REQ-030 All taps=4095, all coefs=4096, one start: result=4095, out_valid exactly 2^N+1 cycles after the start edge, busy high for 4096 cycles.
REQ-031 All taps=0 and any coef, or all coefs=0 and any tap (AND build): result=0.
REQ-032 SC_BIPOLAR_EN build with taps=0 and coefs=0: result=4096; the same stimulus in the AND build gives result=0.
REQ-033 tap[0]=2048, other taps=0, all coefs=4096: result equals the reference-model count (approx. 2048/19, approx. 108), and the exact value matches a golden model of the LFSR and select sequence.
REQ-034 Hold out_ready=0 for 50 cycles in DONE and then pulse it together with start: result stays stable throughout, the next frame begins immediately, and a start pulsed during RUN is ignored.
REQ-035 Assert reset at RUN cycle 1000 and then start again: no out_valid from the aborted frame, and the new frame's result matches a fresh run.
